// File: rtl/match_defs.sv
// Shared constants for the match monitor and the sequence detector bench:
// state encodings and default parameter values.
package match_defs;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_ALARM = 2'd2,
      S_COOL  = 2'd3
   } state_t;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_THRESH = 3;
   localparam int DEF_HOLD   = 4;

endpackage

// File: rtl/rise_detect.sv
// Registers the incoming level and flags its 0->1 transitions.
// The register clears on reset, so a level already high afterwards counts once.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic ans_q;

   always_ff @(posedge clk) begin
      if (reset) ans_q <= 1'b0;
      else       ans_q <= d;
   end

   assign rise = d & ~ans_q;

endmodule

// File: rtl/match_monitor.sv
// Turns match rises into one-cycle events, tallies them in a saturating
// counter, raises a sticky alarm at a threshold and cools down after a clear.
module match_monitor
   import match_defs::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int THRESH = DEF_THRESH,
   parameter int HOLD   = DEF_HOLD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ans_in,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             event_pulse,
   output logic             alarm,
   output logic             cooling
);

   localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [TW-1:0]    TLOAD = TW'(HOLD - 1);
   localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   state_t            state, state_n;
   logic [CNT_W-1:0]  count_n, base;
   logic [TW-1:0]     timer, timer_n;
   logic              pulse_n;
   logic              rise;

   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .d     (ans_in),
      .rise  (rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         count       <= '0;
         timer       <= '0;
         event_pulse <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         timer       <= timer_n;
         event_pulse <= pulse_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      timer_n = timer;
      pulse_n = 1'b0;
      base    = clr ? '0 : count;
      unique case (state)
         S_IDLE, S_COUNT: begin
            count_n = base;
            if (clr) state_n = S_IDLE;
            // A rise coinciding with a clear lands on the zeroed count
            if (rise) begin
               count_n = (base == CMAX) ? base : base + 1'b1;
               pulse_n = 1'b1;
               state_n = (count_n >= THR) ? S_ALARM : S_COUNT;
            end
         end
         S_ALARM: begin
            if (clr) begin
               count_n = '0;
               timer_n = TLOAD;
               state_n = S_COOL;
            end else if (rise) begin
               count_n = (count == CMAX) ? count : count + 1'b1;
               pulse_n = 1'b1;
            end
         end
         S_COOL: begin
            if (clr)              timer_n = TLOAD;
            else if (timer == '0) state_n = S_IDLE;
            else                  timer_n = timer - 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign alarm   = (state == S_ALARM);
   assign cooling = (state == S_COOL);

endmodule

// File: tb/tb_match_monitor.sv
// Directed bench: vector table on a default instance plus a saturation
// sequence on a narrow THRESH=1 instance.
module tb_match_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ans1 = 1'b0, clr1 = 1'b0;
   logic       ans2 = 1'b0, clr2 = 1'b0;
   logic [7:0] count1;
   logic [1:0] count2;
   logic       pulse1, alarm1, cool1;
   logic       pulse2, alarm2, cool2;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   match_monitor u_dut (
      .clk         (clk),
      .reset       (reset),
      .ans_in      (ans1),
      .clr         (clr1),
      .count       (count1),
      .event_pulse (pulse1),
      .alarm       (alarm1),
      .cooling     (cool1)
   );

   match_monitor #(.CNT_W(2), .THRESH(1), .HOLD(4)) u_sat (
      .clk         (clk),
      .reset       (reset),
      .ans_in      (ans2),
      .clr         (clr2),
      .count       (count2),
      .event_pulse (pulse2),
      .alarm       (alarm2),
      .cooling     (cool2)
   );

   typedef struct {
      logic rst;
      logic ans;
      logic clr;
      int   cnt;
      logic p;
      logic a;
      logic c;
   } vec_t;

   localparam int NV = 51;

   task automatic chk(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v[NV];
      int   npulse;
      int   rises;
      int   expc;
      v = '{
         '{1,0,0, 0,0,0,0},
         '{0,0,0, 0,0,0,0},
         '{0,1,0, 1,1,0,0},
         '{0,0,0, 1,0,0,0},
         '{0,1,0, 2,1,0,0},
         '{0,1,0, 2,0,0,0},
         '{0,1,0, 2,0,0,0},
         '{0,0,0, 2,0,0,0},
         '{0,1,0, 3,1,1,0},
         '{0,1,1, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,1,0, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,1,0, 0,0,0,0},
         '{0,0,0, 0,0,0,0},
         '{0,1,0, 1,1,0,0},
         '{0,0,0, 1,0,0,0},
         '{0,1,0, 2,1,0,0},
         '{0,0,0, 2,0,0,0},
         '{0,1,1, 1,1,0,0},
         '{0,0,0, 1,0,0,0},
         '{0,1,0, 2,1,0,0},
         '{0,0,0, 2,0,0,0},
         '{0,1,0, 3,1,1,0},
         '{0,0,0, 3,0,1,0},
         '{0,1,0, 4,1,1,0},
         '{0,1,1, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,0,1, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,0,1, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,0,0, 0,0,0,1},
         '{0,0,0, 0,0,0,0},
         '{0,1,0, 1,1,0,0},
         '{0,0,0, 1,0,0,0},
         '{0,1,0, 2,1,0,0},
         '{0,0,0, 2,0,0,0},
         '{0,1,0, 3,1,1,0},
         '{0,0,1, 0,0,0,1},
         '{1,0,0, 0,0,0,0},
         '{1,1,0, 0,0,0,0},
         '{0,1,0, 1,1,0,0},
         '{0,1,0, 1,0,0,0},
         '{0,0,0, 1,0,0,0},
         '{0,1,0, 2,1,0,0},
         '{0,0,0, 2,0,0,0},
         '{0,1,0, 3,1,1,0},
         '{1,1,0, 0,0,0,0},
         '{0,1,0, 1,1,0,0}
      };

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset = v[i].rst;
         ans1  = v[i].ans;
         clr1  = v[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d count", i), int'(count1), v[i].cnt);
         chk($sformatf("v%0d pulse", i), int'(pulse1), int'(v[i].p));
         chk($sformatf("v%0d alarm", i), int'(alarm1), int'(v[i].a));
         chk($sformatf("v%0d cooling", i), int'(cool1), int'(v[i].c));
      end

      @(negedge clk);
      reset = 1'b1;
      ans1  = 1'b0;
      clr1  = 1'b0;
      ans2  = 1'b0;
      @(posedge clk);
      #1;
      chk("sat reset count", int'(count2), 0);
      chk("sat reset alarm", int'(alarm2), 0);

      npulse = 0;
      rises  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         reset = 1'b0;
         ans2  = (i % 2 == 0);
         @(posedge clk);
         #1;
         if (i % 2 == 0) rises++;
         expc = (rises > 3) ? 3 : rises;
         if (pulse2) npulse++;
         chk($sformatf("sat%0d count", i), int'(count2), expc);
         chk($sformatf("sat%0d pulse", i), int'(pulse2), int'(i % 2 == 0));
         chk($sformatf("sat%0d alarm", i), int'(alarm2), 1);
      end
      chk("sat pulse total", npulse, 6);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   logic prev_pulse1 = 1'b0;

   always @(posedge clk) begin
      #2;
      if (alarm1 && cool1) begin
         nerr++;
         $display("FAIL excl: alarm=%0d cooling=%0d both high", alarm1, cool1);
      end
      if (!reset && prev_pulse1 && pulse1) begin
         nerr++;
         $display("FAIL back2back: pulse=%0d prev=%0d", pulse1, prev_pulse1);
      end
      prev_pulse1 = pulse1;
   end

endmodule
